// File: rtl/surrogate_deriv_lut.sv
// surrogate_deriv_lut: banked, runtime-writable surrogate-derivative table with a 2-stage multi-lane lookup pipeline
module surrogate_deriv_lut #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int IN_WIDTH   = 12,
    parameter int SHIFT      = 2,
    parameter int NUM_LANES  = 4,
    parameter int NUM_BANKS  = 2,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_we,
    input  logic [BANK_W-1:0]               cfg_bank,
    input  logic [ADDR_WIDTH-1:0]           cfg_addr,
    input  logic [DATA_WIDTH-1:0]           cfg_wdata,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BANK_W-1:0]               in_bank,
    input  logic [NUM_LANES*IN_WIDTH-1:0]   in_vmem,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_deriv,
    output logic [NUM_LANES-1:0]            out_clamp
);

    localparam logic signed [IN_WIDTH+1:0] BIAS = (IN_WIDTH+2)'(2**(ADDR_WIDTH-1));
    localparam logic signed [IN_WIDTH+1:0] MAXB = (IN_WIDTH+2)'(2**ADDR_WIDTH - 1);

    logic [DATA_WIDTH-1:0]                  table_mem [NUM_BANKS][2**ADDR_WIDTH];
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]   lane_addr;
    logic [NUM_LANES-1:0]                   lane_clamp;
    logic                                   v1;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]   s1_addr;
    logic [NUM_LANES-1:0]                   s1_clamp;
    logic [BANK_W-1:0]                      s1_bank;
    logic [NUM_LANES*DATA_WIDTH-1:0]        rd_data;
    logic                                   wr_ok;
    logic                                   rd_ok;
    logic                                   s1_adv;
    logic                                   s2_adv;
    logic                                   accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !v1 || s2_adv;
    assign in_ready = s1_adv && !cfg_we;
    assign accept   = in_valid && in_ready;

    // Bank range checks collapse to constants when every select code maps to a real bank
    if (NUM_BANKS == 2**BANK_W) begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part
        assign wr_ok = {1'b0, cfg_bank} < (BANK_W+1)'(NUM_BANKS);
        assign rd_ok = {1'b0, s1_bank} < (BANK_W+1)'(NUM_BANKS);
    end

    // Per lane: shift, bias into table range, saturate; S2 read of the S1 address
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [IN_WIDTH-1:0] s;
        logic signed [IN_WIDTH+1:0] b;
        assign s = $signed(in_vmem[i*IN_WIDTH +: IN_WIDTH]) >>> SHIFT;
        assign b = $signed({{2{s[IN_WIDTH-1]}}, s}) + BIAS;
        assign lane_clamp[i] = b[IN_WIDTH+1] || (b > MAXB);
        assign lane_addr[i]  = b[IN_WIDTH+1] ? '0 : (b > MAXB) ? '1 : b[ADDR_WIDTH-1:0];
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_ok ? table_mem[s1_bank][s1_addr[i]] : '0;
    end

    // Table storage: writes land at the edge, so a same-edge read still sees the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            table_mem <= '{default: '0};
        else if (cfg_we && wr_ok)
            table_mem[cfg_bank][cfg_addr] <= cfg_wdata;
    end

    // S1: capture mapped addresses, clamp flags and bank of an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            s1_addr  <= '0;
            s1_clamp <= '0;
            s1_bank  <= '0;
        end else if (s1_adv) begin
            v1 <= accept;
            if (accept) begin
                s1_addr  <= lane_addr;
                s1_clamp <= lane_clamp;
                s1_bank  <= in_bank;
            end
        end
    end

    // S2: register table contents and clamp flags; an empty S1 moves a bubble forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_deriv <= '0;
            out_clamp <= '0;
        end else if (s2_adv) begin
            out_valid <= v1;
            if (v1) begin
                out_deriv <= rd_data;
                out_clamp <= rd_ok ? s1_clamp : '0;
            end
        end
    end

endmodule

// File: tb/tb_surrogate_deriv_lut.sv
// tb_surrogate_deriv_lut: directed bench with a queue-based reference model of the lookup table
module tb_surrogate_deriv_lut;

    typedef struct packed {
        logic        bank;
        logic [47:0] vm;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic        cfg_bank;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        in_valid;
    logic        in_ready;
    logic        in_bank;
    logic [47:0] in_vmem;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_deriv;
    logic [3:0]  out_clamp;

    int          checks = 0;
    int          errors = 0;
    req_t        q[$];
    logic [7:0]  mm [2][256];
    logic        exp_valid = 1'b0;
    logic [31:0] exp_deriv = '0;
    logic [3:0]  exp_clamp = '0;
    logic        free;
    logic        acc;
    logic        cap;
    logic [7:0]  got[$];
    logic [7:0]  sexp [8];

    surrogate_deriv_lut dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_bank  (cfg_bank),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bank   (in_bank),
        .in_vmem   (in_vmem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_deriv (out_deriv),
        .out_clamp (out_clamp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {12'(l3), 12'(l2), 12'(l1), 12'(l0)};
    endfunction

    // Floor-divide by 4, bias by 128, saturate into 0..255, then read the model table
    function automatic void lookup(input req_t r, output logic [31:0] d, output logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            logic [11:0] raw;
            int v;
            int s;
            int b;
            int a;
            raw = r.vm[i*12 +: 12];
            v = raw[11] ? int'(raw) - 4096 : int'(raw);
            s = (v >= 0) ? v / 4 : -((3 - v) / 4);
            b = s + 128;
            c[i] = (b < 0) || (b > 255);
            a = (b < 0) ? 0 : (b > 255) ? 255 : b;
            d[i*8 +: 8] = mm[r.bank][a];
        end
    endfunction

    // Reference model: one waiting request slot plus the visible output slot
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            exp_valid = 1'b0;
            exp_deriv = '0;
            exp_clamp = '0;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++)
                    mm[b][a] = 8'h00;
        end else begin
            free = !exp_valid || out_ready;
            acc  = in_valid && (q.size() == 0 || free) && !cfg_we;
            if (free) begin
                if (q.size() > 0) begin
                    lookup(q.pop_front(), exp_deriv, exp_clamp);
                    exp_valid = 1'b1;
                end else begin
                    exp_valid = 1'b0;
                end
            end
            if (cfg_we)
                mm[cfg_bank][cfg_addr] = cfg_wdata;
            if (acc)
                q.push_back('{bank: in_bank, vm: in_vmem});
        end
    end

    // Compare DUT against the model on every falling edge
    initial forever begin
        @(negedge clk);
        check("in_ready", in_ready, (q.size() == 0 || !exp_valid || out_ready) && !cfg_we);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_deriv", out_deriv, exp_deriv);
            check("out_clamp", out_clamp, exp_clamp);
        end
        if (cap && out_valid && out_ready)
            got.push_back(out_deriv[7:0]);
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    task automatic send(input logic b, input logic [47:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_bank  = b;
        in_vmem  = v;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic cfg_write(input logic b, input logic [7:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_bank  = b;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #2;
        cfg_we = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] d, input logic [3:0] c);
        bit seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check({nm, "_deriv"}, out_deriv, d);
                check({nm, "_clamp"}, 32'(out_clamp), 32'(c));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1 at %0t", nm, $time);
        end
    endtask

    initial begin
        sexp = '{8'h00, 8'h5A, 8'h22, 8'h11, 8'hA5, 8'h22, 8'h11, 8'h00};
        rst_n = 1'b1; cfg_we = 1'b0; cfg_bank = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_bank = 1'b0; in_vmem = '0; out_ready = 1'b1; cap = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_deriv", out_deriv, 0);
        check("rst_out_clamp", 32'(out_clamp), 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #2;
        // Latency: vmem 0 maps to entry 128
        send(1'b0, pk(0, 0, 0, 0));
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_early_valid", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_deriv", out_deriv, 32'h0);
        check("lat_clamp", 32'(out_clamp), 0);
        @(posedge clk);
        #2;
        // Bank select: vmem 100 maps to entry 153
        cfg_write(1'b0, 8'd153, 8'h5A);
        cfg_write(1'b1, 8'd153, 8'hA5);
        send(1'b0, pk(100, 0, 0, 0));
        send(1'b1, pk(100, 0, 0, 0));
        in_valid = 1'b0;
        expect_out("bank0", 32'h0000005A, 4'b0000);
        expect_out("bank1", 32'h000000A5, 4'b0000);
        @(posedge clk);
        #2;
        // Saturation boundaries
        cfg_write(1'b0, 8'd0, 8'h11);
        cfg_write(1'b0, 8'd255, 8'h22);
        send(1'b0, pk(600, -600, 508, -512));
        in_valid = 1'b0;
        expect_out("sat", 32'h11221122, 4'b0011);
        @(posedge clk);
        #2;
        // Eight-deep stream with a three-cycle consumer stall
        cap = 1'b1;
        fork
            begin
                send(1'b0, pk(0, 0, 0, 0));
                send(1'b0, pk(100, 0, 0, 0));
                send(1'b0, pk(600, 0, 0, 0));
                send(1'b0, pk(-600, 0, 0, 0));
                send(1'b1, pk(100, 0, 0, 0));
                send(1'b0, pk(508, 0, 0, 0));
                send(1'b0, pk(-512, 0, 0, 0));
                send(1'b0, pk(4, 0, 0, 0));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        cap = 1'b0;
        check("stream_count", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            check($sformatf("stream_%0d", i), got[i], sexp[i]);
        @(posedge clk);
        #2;
        // Write under an in-flight read of the same entry
        send(1'b0, pk(0, 0, 0, 0));
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_bank  = 1'b0;
        cfg_addr  = 8'd128;
        cfg_wdata = 8'h7F;
        @(negedge clk);
        check("rbw_in_ready", in_ready, 0);
        @(posedge clk);
        #2 cfg_we = 1'b0;
        @(negedge clk);
        check("rbw_old_valid", out_valid, 1);
        check("rbw_old_deriv", out_deriv, 32'h0);
        @(posedge clk);
        #2;
        send(1'b0, pk(0, 0, 0, 0));
        in_valid = 1'b0;
        expect_out("rbw_new", 32'h7F7F7F7F, 4'b0000);
        @(posedge clk);
        #2;
        // Asynchronous reset with a full pipeline and loaded table
        out_ready = 1'b0;
        send(1'b0, pk(100, 600, -600, 0));
        send(1'b1, pk(100, 600, -600, 0));
        in_valid = 1'b0;
        check("pre_rst_deriv", out_deriv, 32'h7F11225A);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_deriv", out_deriv, 32'h0);
        check("arst_clamp", 32'(out_clamp), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        send(1'b0, pk(100, 600, -600, 0));
        in_valid = 1'b0;
        expect_out("post_rst0", 32'h0, 4'b0110);
        @(posedge clk);
        #2;
        send(1'b1, pk(100, 600, -600, 0));
        in_valid = 1'b0;
        expect_out("post_rst1", 32'h0, 4'b0110);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
